// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback stage owns the port by default,
// and long-latency results are buffered and written on idle cycles or by a forced drain.
module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_we_i,
   input  logic [4:0]  pipe_waddr_i,
   input  logic [31:0] pipe_wdata_i,
   input  logic        b_valid_i,
   output logic        b_ready_o,
   input  logic [4:0]  b_waddr_i,
   input  logic [31:0] b_wdata_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        stall_o,
   output logic        b_pending_o
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {PIPE = 1'b0, DRAIN = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count, count_nxt;
   logic [CNT_W-1:0]   drain_pops;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               kill [DEPTH];
   logic [4:0]         fifo_addr [DEPTH];
   logic [31:0]        fifo_data [DEPTH];

   logic pipe_eff, head_valid, head_kill, head_live;
   logic grant, deny, pop, push, push_kill, wait_expired, drain_exit;

   assign pipe_eff     = pipe_we_i && (pipe_waddr_i != 5'd0) && (state == PIPE);
   assign head_valid   = (count != '0);
   assign head_kill    = kill[rd_ptr];
   assign head_live    = head_valid && !head_kill;
   assign grant        = head_live && !pipe_eff;
   assign deny         = head_live && pipe_eff;
   assign pop          = head_valid && (head_kill || grant);
   assign b_ready_o    = (count != CNT_W'(DEPTH));
   assign push         = b_valid_i && b_ready_o;
   // A same-cycle pipe write to the same register makes the new entry stale on arrival.
   assign push_kill    = (b_waddr_i == 5'd0) || (pipe_eff && (b_waddr_i == pipe_waddr_i));
   assign count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
   assign wait_expired = (state == PIPE) && deny && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
   assign drain_exit   = (state == DRAIN) &&
                         ((count_nxt == '0) || ((drain_pops + CNT_W'(pop)) == CNT_W'(DEPTH)));
   assign stall_o      = (state == DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PIPE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         PIPE:    if (wait_expired) state_nxt = DRAIN;
         DRAIN:   if (drain_exit)   state_nxt = PIPE;
         default: state_nxt = PIPE;
      endcase
   end

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
      if (pipe_eff) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = pipe_waddr_i;
         rf_wdata_o = pipe_wdata_i;
      end else if (head_live) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = fifo_addr[rd_ptr];
         rf_wdata_o = fifo_data[rd_ptr];
      end
   end

   // An entry is live when it sits inside the occupied window and has not been killed.
   always_comb begin
      logic [PTR_W-1:0] off;
      off         = '0;
      b_pending_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr;
         if ((CNT_W'(off) < count) && !kill[i]) b_pending_o = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         wait_cnt   <= '0;
         drain_pops <= '0;
         for (int i = 0; i < DEPTH; i++) kill[i] <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i)))
               kill[i] <= push_kill;
            else if (pipe_eff && (fifo_addr[i] == pipe_waddr_i))
               kill[i] <= 1'b1;
         end
         if (wait_expired || !deny) wait_cnt <= '0;
         else                       wait_cnt <= wait_cnt + WAIT_W'(1);
         if (state != DRAIN || drain_exit) drain_pops <= '0;
         else                              drain_pops <= drain_pops + CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (wr_ptr == PTR_W'(i))) begin
            fifo_addr[i] <= b_waddr_i;
            fifo_data[i] <= b_wdata_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based model of the port rules.
module tb_wb_port_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_we_i;
   logic [4:0]  pipe_waddr_i;
   logic [31:0] pipe_wdata_i;
   logic        b_valid_i;
   logic        b_ready_o;
   logic [4:0]  b_waddr_i;
   logic [31:0] b_wdata_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        stall_o;
   logic        b_pending_o;

   wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_we_i    (pipe_we_i),
      .pipe_waddr_i (pipe_waddr_i),
      .pipe_wdata_i (pipe_wdata_i),
      .b_valid_i    (b_valid_i),
      .b_ready_o    (b_ready_o),
      .b_waddr_i    (b_waddr_i),
      .b_wdata_i    (b_wdata_i),
      .rf_we_o      (rf_we_o),
      .rf_waddr_o   (rf_waddr_o),
      .rf_wdata_o   (rf_wdata_o),
      .stall_o      (stall_o),
      .b_pending_o  (b_pending_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      bit          k;
   } ent_t;

   ent_t q[$];
   bit   m_drain;
   int   m_wait;
   int   m_dpops;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_drain = 0;
      m_wait  = 0;
      m_dpops = 0;
   endtask

   task automatic step(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      bit          eff, exists, hk, grant, pop, deny, ready, pend, e_we;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      ent_t        e;
      @(negedge clk);
      pipe_we_i = pe; pipe_waddr_i = pa; pipe_wdata_i = pd;
      b_valid_i = bv; b_waddr_i = ba;    b_wdata_i = bd;
      #1;
      eff    = pe && (pa != 0) && !m_drain;
      exists = (q.size() != 0);
      hk     = exists ? q[0].k : 1'b0;
      ready  = (q.size() != DEPTH);
      pend   = 0;
      foreach (q[i]) if (!q[i].k) pend = 1;
      e_we = 0; e_a = 0; e_d = 0;
      if (eff) begin
         e_we = 1; e_a = pa; e_d = pd;
      end else if (exists && !hk) begin
         e_we = 1; e_a = q[0].a; e_d = q[0].d;
      end
      check("rf_we",     rf_we_o,     e_we);
      check("rf_waddr",  rf_waddr_o,  e_a);
      check("rf_wdata",  rf_wdata_o,  e_d);
      check("stall",     stall_o,     m_drain);
      check("b_ready",   b_ready_o,   ready);
      check("b_pending", b_pending_o, pend);
      @(posedge clk);
      grant = !eff && exists && !hk;
      deny  = eff && exists && !hk;
      pop   = exists && (hk || grant);
      if (eff) foreach (q[i]) if (q[i].a == pa) q[i].k = 1;
      if (pop) void'(q.pop_front());
      if (bv && ready) begin
         e.a = ba; e.d = bd; e.k = (ba == 0) || (eff && ba == pa);
         q.push_back(e);
      end
      if (!m_drain) begin
         if (deny) begin
            if (m_wait == MAX_WAIT - 1) begin
               m_drain = 1; m_wait = 0; m_dpops = 0;
            end else m_wait++;
         end else m_wait = 0;
      end else begin
         m_wait = 0;
         m_dpops += int'(pop);
         if (q.size() == 0 || m_dpops == DEPTH) begin
            m_drain = 0; m_dpops = 0;
         end
      end
   endtask

   task automatic random_phase(input int cycles);
      int pe_pct, bv_pct;
      for (int c = 0; c < cycles; c++) begin
         if (c % 100 == 0) begin
            pe_pct = $urandom_range(0, 3) * 30;
            bv_pct = $urandom_range(10, 70);
         end
         step($urandom_range(0, 99) < pe_pct, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < bv_pct, 5'($urandom_range(0, 7)), $urandom);
      end
   endtask

   initial begin
      bit reached;
      rst_n = 1'b0;
      pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
      b_valid_i = 0; b_waddr_i = 0;    b_wdata_i = 0;
      model_reset();
      #1;
      check("rst_stall",   stall_o,     1'b0);
      check("rst_rf_we",   rf_we_o,     1'b0);
      check("rst_pending", b_pending_o, 1'b0);
      check("rst_ready",   b_ready_o,   1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      random_phase(2000);

      // Build a forced drain, then reset while one entry remains.
      step(1, 5'd3, 32'h33, 1, 5'd7, 32'hAA);
      step(1, 5'd3, 32'h33, 1, 5'd8, 32'hBB);
      reached = 0;
      for (int c = 0; c < 20 && !reached; c++) begin
         step(1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
         reached = m_drain && (q.size() == 1);
      end
      check("reach_drain", reached, 1'b1);
      @(negedge clk);
      pipe_we_i = 0; b_valid_i = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_stall",   stall_o,     1'b0);
      check("mid_rst_rf_we",   rf_we_o,     1'b0);
      check("mid_rst_pending", b_pending_o, 1'b0);
      check("mid_rst_ready",   b_ready_o,   1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      random_phase(600);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline's writeback stage and one long-latency functional unit, such as the iterative divider. The writeback stage gets the port by default. Results from the long-latency unit go into a small FIFO and are written on idle port cycles. If a result waits too long, the block stalls the pipeline and drains it. The block sits between the writeback stage outputs and the register file write port, and resolves write-after-write (WAW) conflicts in the pipeline's favour.

## Interface
- DEPTH, 2, FIFO entries for long-latency results; power of two, >= 2
- MAX_WAIT, 4, consecutive denied cycles before a forced drain; >= 1
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- pipe_we_i  in  1  writeback-stage write enable
- pipe_waddr_i  in  5  writeback-stage destination register
- pipe_wdata_i  in  32  writeback-stage write data
- b_valid_i  in  1  long-latency unit result valid
- b_ready_o  out  1  FIFO can accept; equals (count != DEPTH)
- b_waddr_i  in  5  long-latency result destination register
- b_wdata_i  in  32  long-latency result data
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- stall_o  out  1  freeze pipeline; equals (state == DRAIN)
- b_pending_o  out  1  FIFO holds at least one live (unkilled) entry

## Operation
- Pipe write is effective when pipe_we_i = 1, pipe_waddr_i != 0 and state = PIPE.
- A write to x0 is never effective.
- Push: b_valid_i && b_ready_o. The entry stores addr, data and kill = 0.
- A pushed entry with addr 0 is stored with kill = 1.
- WAW rule: an effective pipe write sets kill on every FIFO entry with a matching addr, including an entry pushed in the same cycle.
- System invariant: a long-latency instruction is always older than any instruction reaching writeback in or after its push cycle.
- Port mux, combinational, priority order:
  1. Effective pipe write: drive pipe_* onto rf_*.
  2. Otherwise, FIFO head valid and not killed: drive head onto rf_*, rf_we_o = 1, pop.
  3. Otherwise: rf_we_o = 0. When rf_we_o = 0, rf_waddr_o and rf_wdata_o = 0.
- A killed head is popped in any cycle without asserting rf_we_o. At most one pop per cycle.
- Push and pop in the same cycle are allowed when count = DEPTH is not exceeded. b_ready_o is not combinationally dependent on the pop.
- Wait counter: increments when a live head is not granted; clears on grant, on an empty FIFO, or on a killed head.
- FSM states: PIPE, DRAIN.
- PIPE -> DRAIN: when the counter = MAX_WAIT-1 and the head is not granted this cycle.
- DRAIN:
  - stall_o = 1 and pipe_we_i is ignored (the pipeline holds its writeback instruction).
  - A live head is written every cycle.
  - Exit to PIPE after the cycle in which the FIFO becomes empty, or after DEPTH pops, whichever comes first.
  - The counter clears on entry to DRAIN.
- Pushes are still accepted in DRAIN.

## Timing
- Reset values:
  - FIFO empty, all kill bits 0, counter 0, state PIPE.
  - stall_o = 0, rf_we_o = 0, b_pending_o = 0, b_ready_o = 1.
- Reset asserted mid-DRAIN discards all FIFO contents immediately. stall_o drops without waiting for the clock.
- Pipe path latency: 0 cycles (combinational through to rf_*).
- Long-latency path: a result pushed at edge N can be written no earlier than the cycle after edge N.
- Worst-case wait for a live head: MAX_WAIT denied cycles plus 1 DRAIN cycle.
- stall_o is a registered state output. It rises on the edge after the MAX_WAIT-th denied cycle and falls on the edge after the exit condition.
- FIFO full with b_valid_i = 1: no push; the unit holds its result until b_ready_o = 1.
- Pointers wrap modulo DEPTH.

## Test plan
- Idle port use: pipe_we_i = 0, push (x5, 0x1234). The next cycle gives rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0x1234; b_pending_o then falls.
- Priority: pipe writes x3 every cycle, push (x7, 0xAA), MAX_WAIT = 4. x7 stays buffered for 4 cycles, then stall_o = 1 for exactly 1 cycle, writing x7 = 0xAA. stall_o = 0 on the following cycle.
- WAW kill: push (x9, 0x11), then a pipe write of x9 = 0x22 in the same cycle as a live head. rf_* shows x9 = 0x22; the x9 = 0x11 entry is popped without a write; b_pending_o = 0.
- Full FIFO, DEPTH = 2: push 2 entries while the pipe writes continuously. b_ready_o = 0, and a third b_valid_i is held. After the forced drain writes both entries (2 DRAIN cycles), the third is accepted.
- x0 filtering: pipe_we_i = 1 with pipe_waddr_i = 0 lets a live head take the port that cycle. A pushed (x0, 0xFF) entry never asserts rf_we_o.
- Reset mid-drain: assert rst_n = 0 during DRAIN with 1 entry left. stall_o, rf_we_o and b_pending_o go to 0 immediately, and b_ready_o goes to 1.
